// File: rtl/ring_pkg.sv
// Shared types and ring helpers for ring-counter decode and monitoring.
// Helpers work on a RING_W_MAX-bit container; callers pass the real ring width.
package ring_pkg;

   typedef enum logic {ACQUIRE, LOCKED} state_t;

   localparam int DEFAULT_WIDTH = 4;
   localparam int RING_W_MAX    = 32;
   localparam int IDX_W_MAX     = 5;

   typedef struct packed {
      logic                 valid;
      logic [IDX_W_MAX-1:0] idx;
   } onehot_t;

   // Expected successor of a one-hot ring value, bits above width cleared.
   function automatic logic [RING_W_MAX-1:0] ring_next(
      input logic [RING_W_MAX-1:0] value,
      input int                    width,
      input logic                  shift_left
   );
      logic [RING_W_MAX-1:0] mask;
      logic [RING_W_MAX-1:0] rot;
      mask = (width >= RING_W_MAX) ? '1 : ((RING_W_MAX'(1) << width) - RING_W_MAX'(1));
      if (shift_left)
         rot = (value << 1) | (value >> (width - 1));
      else
         rot = (value >> 1) | (value << (width - 1));
      return rot & mask;
   endfunction

   function automatic onehot_t onehot_idx(
      input logic [RING_W_MAX-1:0] value,
      input int                    width
   );
      onehot_t r;
      int      cnt;
      r   = '0;
      cnt = 0;
      for (int i = 0; i < RING_W_MAX; i++) begin
         if (i < width && value[i]) begin
            cnt++;
            r.idx = IDX_W_MAX'(i);
         end
      end
      r.valid = (cnt == 1);
      if (!r.valid) r.idx = '0;
      return r;
   endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// Bus between a ring counter (master side) and the ring monitor (slave side).
interface ring_monitor_if #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
);
   localparam int IDX_W = $clog2(WIDTH);

   logic             en;
   logic             clr_err;
   logic [WIDTH-1:0] ring_in;
   logic [IDX_W-1:0] idx_out;
   logic             onehot_ok;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;

   modport master (
      output en, clr_err, ring_in,
      input  idx_out, onehot_ok, locked, err_pulse, err_count
   );

   modport slave (
      input  en, clr_err, ring_in,
      output idx_out, onehot_ok, locked, err_pulse, err_count
   );
endinterface

// File: rtl/ring_onehot_dec.sv
// Combinational one-hot check and binary decode of a ring value (WIDTH <= 32).
module ring_onehot_dec
   import ring_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] ring,
   output logic             oh,
   output logic [IDX_W-1:0] idx
);
   onehot_t dec;

   always_comb begin
      dec = onehot_idx(RING_W_MAX'(ring), WIDTH);
      oh  = dec.valid;
      idx = IDX_W'(dec.idx);
   end
endmodule

// File: rtl/ring_monitor.sv
// Ring counter health monitor: one-hot/direction check, lock FSM, decode
// to a binary index and a saturating error count.
module ring_monitor
   import ring_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter bit SHIFT_LEFT = 1'b1,
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 8
) (
   input logic           clk,
   input logic           rst,
   ring_monitor_if.slave bus
);
   localparam int IDX_W = $clog2(WIDTH);

   state_t           state_q;
   logic [7:0]       step_q;
   logic [WIDTH-1:0] prev_q;
   logic             ref_valid_q;
   logic [IDX_W-1:0] idx_q;
   logic             onehot_ok_q;
   logic             locked_q;
   logic             err_pulse_q;
   logic [ERR_W-1:0] err_count_q;

   logic             oh;
   logic [IDX_W-1:0] dec_idx;
   logic [WIDTH-1:0] exp_ring;
   logic             good;
   logic             err_evt;

   ring_onehot_dec #(.WIDTH(WIDTH)) u_dec (
      .ring (bus.ring_in),
      .oh   (oh),
      .idx  (dec_idx)
   );

   // A held value never equals its rotation, so a stuck ring fails `good`.
   assign exp_ring = WIDTH'(ring_next(RING_W_MAX'(prev_q), WIDTH, SHIFT_LEFT));
   assign good     = oh && ref_valid_q && (bus.ring_in == exp_ring);
   assign err_evt  = bus.en && (state_q == LOCKED) && !good;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACQUIRE;
         step_q      <= '0;
         prev_q      <= '0;
         ref_valid_q <= 1'b0;
         idx_q       <= '0;
         onehot_ok_q <= 1'b0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         // NOTE: non-blocking throughout; later assignments in this block override the defaults.
         err_pulse_q <= 1'b0;

         // Clear wins first, so an error on the same edge leaves a count of 1.
         if (bus.clr_err)
            err_count_q <= err_evt ? ERR_W'(1) : '0;
         else if (err_evt && err_count_q != {ERR_W{1'b1}})
            err_count_q <= err_count_q + 1'b1;

         if (bus.en) begin
            idx_q       <= oh ? dec_idx : '0;
            onehot_ok_q <= oh;
            ref_valid_q <= oh;
            if (oh) prev_q <= bus.ring_in;

            case (state_q)
               ACQUIRE: begin
                  if (good) begin
                     if (step_q == 8'(LOCK_COUNT - 1)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        step_q   <= '0;
                     end else begin
                        step_q <= step_q + 1'b1;
                     end
                  end else begin
                     step_q <= '0;
                  end
               end
               LOCKED: begin
                  if (!good) begin
                     state_q     <= ACQUIRE;
                     locked_q    <= 1'b0;
                     err_pulse_q <= 1'b1;
                     step_q      <= '0;
                  end
               end
               default: state_q <= ACQUIRE;
            endcase
         end
      end
   end

   assign bus.idx_out   = idx_q;
   assign bus.onehot_ok = onehot_ok_q;
   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor (WIDTH=4, SHIFT_LEFT=1, LOCK_COUNT=4, ERR_W=8).
module tb_ring_monitor;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ring_monitor_if #(.WIDTH(4), .ERR_W(8)) bus ();

   ring_monitor #(
      .WIDTH(4), .SHIFT_LEFT(1'b1), .LOCK_COUNT(4), .ERR_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive at negedge, let one rising edge pass, then settle 1 time unit.
   task automatic step(input logic [3:0] ring, input logic en, input logic clr);
      @(negedge clk);
      bus.ring_in = ring;
      bus.en      = en;
      bus.clr_err = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = 1'b0; bus.clr_err = 1'b0; bus.ring_in = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.idx_out !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", bus.idx_out); end
      checks++; if (bus.onehot_ok !== 1'b0) begin errors++; $display("FAIL reset_oh got %b want 0", bus.onehot_ok); end
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", bus.locked); end
      checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", bus.err_pulse); end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.err_count); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lock();
      logic [3:0] rings [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] idxs  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic       lks   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         step(rings[i], 1'b1, 1'b0);
         checks++; if (bus.idx_out !== idxs[i]) begin errors++; $display("FAIL lock_idx[%0d] got %0d want %0d", i, bus.idx_out, idxs[i]); end
         checks++; if (bus.locked !== lks[i]) begin errors++; $display("FAIL lock_locked[%0d] got %b want %b", i, bus.locked, lks[i]); end
         checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL lock_pulse[%0d] got %b want 0", i, bus.err_pulse); end
      end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL lock_count got %0d want 0", bus.err_count); end
   endtask

   task automatic test_multihot();
      logic [3:0] rings [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      step(4'b0110, 1'b1, 1'b0);
      checks++; if (bus.onehot_ok !== 1'b0) begin errors++; $display("FAIL mh_oh got %b want 0", bus.onehot_ok); end
      checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL mh_pulse got %b want 1", bus.err_pulse); end
      checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL mh_count got %0d want 1", bus.err_count); end
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL mh_locked got %b want 0", bus.locked); end
      checks++; if (bus.idx_out !== 2'd0) begin errors++; $display("FAIL mh_idx got %0d want 0", bus.idx_out); end
      for (int i = 0; i < 5; i++) begin
         step(rings[i], 1'b1, 1'b0);
         checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL mh_resume_pulse[%0d] got %b want 0", i, bus.err_pulse); end
         checks++; if (bus.locked !== (i == 4)) begin errors++; $display("FAIL mh_relock[%0d] got %b want %b", i, bus.locked, (i == 4)); end
      end
      checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL mh_count_hold got %0d want 1", bus.err_count); end
   endtask

   task automatic test_skip();
      logic [3:0] rings [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      step(4'b0000, 1'b0, 1'b1);  // clr_err with en=0
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL clr_alone got %0d want 0", bus.err_count); end
      checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL clr_en0_locked got %b want 1", bus.locked); end
      step(4'b0010, 1'b1, 1'b0);
      checks++; if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0) begin errors++; $display("FAIL skip_pre got lk=%b p=%b want lk=1 p=0", bus.locked, bus.err_pulse); end
      step(4'b1000, 1'b1, 1'b0);
      checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL skip_pulse got %b want 1", bus.err_pulse); end
      checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL skip_count got %0d want 1", bus.err_count); end
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL skip_locked got %b want 0", bus.locked); end
      checks++; if (bus.idx_out !== 2'd3) begin errors++; $display("FAIL skip_idx got %0d want 3", bus.idx_out); end
      for (int i = 0; i < 4; i++) begin
         step(rings[i], 1'b1, 1'b0);
         checks++; if (bus.locked !== (i == 3)) begin errors++; $display("FAIL skip_relock[%0d] got %b want %b", i, bus.locked, (i == 3)); end
      end
   endtask

   task automatic test_en_gap();
      step(4'b0000, 1'b1, 1'b0);  // zero while locked: error, drops reference
      checks++; if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'd2) begin errors++; $display("FAIL gap_zero got p=%b c=%0d want p=1 c=2", bus.err_pulse, bus.err_count); end
      step(4'b0001, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL gap_en0_pulse got %b want 0", bus.err_pulse); end
      step(4'b0000, 1'b0, 1'b0);
      checks++; if (bus.onehot_ok !== 1'b1 || bus.idx_out !== 2'd1) begin errors++; $display("FAIL gap_hold got oh=%b idx=%0d want oh=1 idx=1", bus.onehot_ok, bus.idx_out); end
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      step(4'b1000, 1'b1, 1'b0);
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL gap_early got %b want 0", bus.locked); end
      step(4'b1000, 1'b0, 1'b0);
      step(4'b0001, 1'b1, 1'b0);
      checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL gap_lock got %b want 1", bus.locked); end
      step(4'b0010, 1'b1, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      checks++; if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0 || bus.err_count !== 8'd2) begin
         errors++; $display("FAIL gap_locked_en got lk=%b p=%b c=%0d want lk=1 p=0 c=2", bus.locked, bus.err_pulse, bus.err_count);
      end
   endtask

   task automatic test_saturation();
      logic [3:0] rings [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      int exp_cnt;
      exp_cnt = 2;
      for (int n = 0; n < 300; n++) begin
         step(4'b0000, 1'b1, 1'b0);
         if (exp_cnt < 255) exp_cnt++;
         checks++; if (bus.err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", n, bus.err_count, exp_cnt); end
         for (int i = 0; i < 5; i++) step(rings[i], 1'b1, 1'b0);
      end
      checks++; if (bus.err_count !== 8'd255 || bus.locked !== 1'b1) begin errors++; $display("FAIL sat_final got c=%0d lk=%b want c=255 lk=1", bus.err_count, bus.locked); end
      step(4'b0000, 1'b1, 1'b1);
      checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL clr_with_err got %0d want 1", bus.err_count); end
      checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL clr_with_err_pulse got %b want 1", bus.err_pulse); end
   endtask

   task automatic test_async_reset();
      logic [3:0] rings [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 5; i++) step(rings[i], 1'b1, 1'b0);
         step(4'b0000, 1'b1, 1'b0);
      end
      for (int i = 0; i < 5; i++) step(rings[i], 1'b1, 1'b0);
      checks++; if (bus.err_count !== 8'd5 || bus.locked !== 1'b1) begin errors++; $display("FAIL ar_pre got c=%0d lk=%b want c=5 lk=1", bus.err_count, bus.locked); end
      @(negedge clk);
      bus.ring_in = 4'b1000;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.locked !== 1'b0 || bus.err_count !== 8'd0 || bus.onehot_ok !== 1'b0 || bus.idx_out !== 2'd0 || bus.err_pulse !== 1'b0) begin
         errors++; $display("FAIL ar_async got lk=%b c=%0d oh=%b idx=%0d p=%b want all 0", bus.locked, bus.err_count, bus.onehot_ok, bus.idx_out, bus.err_pulse);
      end
      @(negedge clk);
      rst = 1'b0;
      step(4'b0100, 1'b1, 1'b0);
      checks++; if (bus.err_pulse !== 1'b0 || bus.locked !== 1'b0) begin errors++; $display("FAIL ar_first got p=%b lk=%b want p=0 lk=0", bus.err_pulse, bus.locked); end
      checks++; if (bus.onehot_ok !== 1'b1 || bus.idx_out !== 2'd2 || bus.err_count !== 8'd0) begin
         errors++; $display("FAIL ar_first_dec got oh=%b idx=%0d c=%0d want oh=1 idx=2 c=0", bus.onehot_ok, bus.idx_out, bus.err_count);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_lock();
      test_multihot();
      test_skip();
      test_en_gap();
      test_saturation();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
